// File: rtl/spidergon_flit_injector.sv
// spidergon_flit_injector: packetises local messages into head/body/tail flits
// and issues them into the node's per-VC input buffers under credit flow control.
module spidergon_flit_injector #(
  parameter int NUM_OF_NODES = 8,
  parameter int FLIT_DATA_WIDTH = 16,
  parameter int NODE_BUFFER_WIDTH = 32,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int NODE_ID = 0,
  localparam int DESTW = $clog2(NUM_OF_NODES),
  localparam int VCW = NUM_OF_VIRTUAL_CHANNELS > 1 ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_msg_valid,
  output logic                               o_msg_ready,
  input  logic [DESTW-1:0]                   i_msg_dest,
  input  logic [3:0]                         i_msg_len,
  input  logic                               i_pld_valid,
  output logic                               o_pld_ready,
  input  logic [FLIT_DATA_WIDTH-1:0]         i_pld_data,
  output logic                               o_flit_valid,
  output logic [1:0]                         o_flit_type,
  output logic [VCW-1:0]                     o_flit_vc,
  output logic [FLIT_DATA_WIDTH-1:0]         o_flit_data,
  input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] i_credit_return,
  output logic                               o_credit_overflow
);
  localparam int NVC = NUM_OF_VIRTUAL_CHANNELS;
  localparam int CREDITS = NODE_BUFFER_WIDTH / FLIT_DATA_WIDTH;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  localparam logic [DESTW-1:0] SRC = DESTW'(NODE_ID);
  typedef enum logic [1:0] {IDLE, HEAD, BODY, DROP} state_t;
  state_t r_state;
  logic [DESTW-1:0] r_dest;
  logic [3:0] r_len, r_rem;
  logic [VCW-1:0] r_vc, w_sel, w_send_vc;
  logic [CW-1:0] r_cred [NVC];
  logic [NVC-1:0] w_has;
  logic w_send, w_msg_hs, w_pld_hs;
  logic [1:0] w_type;
  logic [FLIT_DATA_WIDTH-1:0] w_head;

  // Descending scan so the lowest-indexed VC with credit wins
  always_comb begin
    w_sel = '0;
    w_has = '0;
    for (int v = NVC - 1; v >= 0; v--) begin
      w_has[v] = r_cred[v] != '0;
      if (w_has[v]) w_sel = VCW'(v);
    end
  end

  always_comb begin
    w_head = '0;
    w_head[DESTW-1:0] = r_dest;
    w_head[2*DESTW-1:DESTW] = SRC;
  end

  assign o_msg_ready = i_rst_n && r_state == IDLE;
  assign o_pld_ready = r_state == DROP || (r_state == BODY && w_has[r_vc]);
  assign w_msg_hs = i_msg_valid && o_msg_ready;
  assign w_pld_hs = i_pld_valid && o_pld_ready;
  assign w_send = (r_state == HEAD && |w_has) || (r_state == BODY && w_pld_hs);
  assign w_send_vc = r_state == HEAD ? w_sel : r_vc;
  assign w_type = r_state == HEAD ? (r_len == '0 ? 2'b11 : 2'b00) : (r_rem == 4'd1 ? 2'b10 : 2'b01);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_dest <= '0;
      r_len <= '0;
      r_rem <= '0;
      r_vc <= '0;
      o_flit_valid <= 1'b0;
      o_flit_type <= 2'b00;
      o_flit_vc <= '0;
      o_flit_data <= '0;
      o_credit_overflow <= 1'b0;
      for (int v = 0; v < NVC; v++) r_cred[v] <= FULL;
    end else begin
      o_flit_valid <= w_send;
      if (w_send) begin
        o_flit_type <= w_type;
        o_flit_vc <= w_send_vc;
        o_flit_data <= r_state == HEAD ? w_head : i_pld_data;
      end
      // A return and a send on the same VC in one cycle cancel out
      for (int v = 0; v < NVC; v++) begin
        if (i_credit_return[v] && !(w_send && w_send_vc == VCW'(v))) begin
          if (r_cred[v] == FULL) o_credit_overflow <= 1'b1;
          else r_cred[v] <= r_cred[v] + CW'(1);
        end else if (!i_credit_return[v] && w_send && w_send_vc == VCW'(v)) begin
          r_cred[v] <= r_cred[v] - CW'(1);
        end
      end
      case (r_state)
        IDLE: if (w_msg_hs) begin
          r_dest <= i_msg_dest;
          r_len <= i_msg_len;
          r_rem <= i_msg_len;
          r_state <= i_msg_dest == SRC ? (i_msg_len == '0 ? IDLE : DROP) : HEAD;
        end
        HEAD: if (w_send) begin
          r_vc <= w_sel;
          r_state <= r_len == '0 ? IDLE : BODY;
        end
        BODY, DROP: if (w_pld_hs) begin
          r_rem <= r_rem - 4'd1;
          if (r_rem == 4'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spidergon_flit_injector.sv
// tb_spidergon_flit_injector: directed scenarios plus a randomized run scored
// against a packet-level model of the expected flit stream and VC credits.
module tb_spidergon_flit_injector;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_msg_valid = 1'b0;
  logic o_msg_ready;
  logic [2:0] i_msg_dest = '0;
  logic [3:0] i_msg_len = '0;
  logic i_pld_valid = 1'b0;
  logic o_pld_ready;
  logic [15:0] i_pld_data = '0;
  logic o_flit_valid;
  logic [1:0] o_flit_type;
  logic o_flit_vc;
  logic [15:0] o_flit_data;
  logic [1:0] i_credit_return = '0;
  logic o_credit_overflow;
  int n_chk = 0;
  int n_pass = 0;

  spidergon_flit_injector dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_msg_valid(i_msg_valid), .o_msg_ready(o_msg_ready), .i_msg_dest(i_msg_dest), .i_msg_len(i_msg_len),
    .i_pld_valid(i_pld_valid), .o_pld_ready(o_pld_ready), .i_pld_data(i_pld_data),
    .o_flit_valid(o_flit_valid), .o_flit_type(o_flit_type), .o_flit_vc(o_flit_vc), .o_flit_data(o_flit_data),
    .i_credit_return(i_credit_return), .o_credit_overflow(o_credit_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== 20'h0) $display("FAIL reset_flit: got %h exp 00000", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}); else n_pass++;
    n_chk++; if (o_credit_overflow !== 1'b0) $display("FAIL reset_overflow: got %b exp 0", o_credit_overflow); else n_pass++;
    n_chk++; if (o_msg_ready !== 1'b0) $display("FAIL reset_msg_ready: got %b exp 0", o_msg_ready); else n_pass++;
    n_chk++; if (o_pld_ready !== 1'b0) $display("FAIL reset_pld_ready: got %b exp 0", o_pld_ready); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++; if (o_msg_ready !== 1'b1) $display("FAIL post_reset_msg_ready: got %b exp 1", o_msg_ready); else n_pass++;
    n_chk++; if ({dut.r_cred[0], dut.r_cred[1]} !== 4'b1010) $display("FAIL post_reset_credits: got %h exp a", {dut.r_cred[0], dut.r_cred[1]}); else n_pass++;
  endtask

  task automatic test_head_only();
    i_msg_valid = 1'b1; i_msg_dest = 3'd3; i_msg_len = 4'd0;
    tick();
    i_msg_valid = 1'b0;
    tick();
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b11, 1'b0, 16'h0003}) $display("FAIL head_only_flit: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b11, 1'b0, 16'h0003}); else n_pass++;
    n_chk++; if (o_msg_ready !== 1'b1) $display("FAIL head_only_msg_ready: got %b exp 1", o_msg_ready); else n_pass++;
    tick();
    n_chk++; if (o_flit_valid !== 1'b0) $display("FAIL head_only_single: got %b exp 0", o_flit_valid); else n_pass++;
    n_chk++; if (dut.r_cred[0] !== 2'd1) $display("FAIL head_only_cred0: got %0d exp 1", dut.r_cred[0]); else n_pass++;
    i_credit_return = 2'b01;
    tick();
    i_credit_return = 2'b00;
  endtask

  task automatic test_credit_stall();
    i_msg_valid = 1'b1; i_msg_dest = 3'd5; i_msg_len = 4'd3;
    i_pld_valid = 1'b1; i_pld_data = 16'h00A1;
    tick();
    i_msg_valid = 1'b0;
    tick();
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b00, 1'b0, 16'h0005}) $display("FAIL stall_head: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b00, 1'b0, 16'h0005}); else n_pass++;
    tick();
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b01, 1'b0, 16'h00A1}) $display("FAIL stall_body1: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b01, 1'b0, 16'h00A1}); else n_pass++;
    i_pld_data = 16'h00A2;
    n_chk++; if (o_pld_ready !== 1'b0) $display("FAIL stall_pld_ready: got %b exp 0", o_pld_ready); else n_pass++;
    tick();
    tick();
    n_chk++; if ({o_flit_valid, o_pld_ready} !== 2'b00) $display("FAIL stall_idle: got %b exp 00", {o_flit_valid, o_pld_ready}); else n_pass++;
    i_credit_return = 2'b01;
    tick();
    i_credit_return = 2'b00;
    n_chk++; if ({o_flit_valid, o_pld_ready} !== 2'b01) $display("FAIL stall_return_next_cycle: got %b exp 01", {o_flit_valid, o_pld_ready}); else n_pass++;
    tick();
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b01, 1'b0, 16'h00A2}) $display("FAIL stall_body2: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b01, 1'b0, 16'h00A2}); else n_pass++;
    i_pld_data = 16'h00A3;
    i_credit_return = 2'b01;
    tick();
    i_credit_return = 2'b00;
    tick();
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b10, 1'b0, 16'h00A3}) $display("FAIL stall_tail: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b10, 1'b0, 16'h00A3}); else n_pass++;
    i_pld_valid = 1'b0;
    n_chk++; if (o_msg_ready !== 1'b1) $display("FAIL stall_msg_ready: got %b exp 1", o_msg_ready); else n_pass++;
  endtask

  task automatic test_vc_select();
    n_chk++; if (dut.r_cred[0] !== 2'd0) $display("FAIL vc_sel_cred0: got %0d exp 0", dut.r_cred[0]); else n_pass++;
    i_msg_valid = 1'b1; i_msg_dest = 3'd2; i_msg_len = 4'd1;
    i_pld_valid = 1'b1; i_pld_data = 16'h5A5A;
    tick();
    i_msg_valid = 1'b0;
    tick();
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b00, 1'b1, 16'h0002}) $display("FAIL vc_sel_head: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b00, 1'b1, 16'h0002}); else n_pass++;
    tick();
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b10, 1'b1, 16'h5A5A}) $display("FAIL vc_sel_tail: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b10, 1'b1, 16'h5A5A}); else n_pass++;
    i_pld_valid = 1'b0;
    n_chk++; if (dut.r_cred[1] !== 2'd0) $display("FAIL vc_sel_cred1: got %0d exp 0", dut.r_cred[1]); else n_pass++;
  endtask

  task automatic test_same_cycle_overflow();
    i_credit_return = 2'b10;
    tick();
    i_credit_return = 2'b00;
    i_msg_valid = 1'b1; i_msg_dest = 3'd4; i_msg_len = 4'd0;
    tick();
    i_msg_valid = 1'b0;
    i_credit_return = 2'b10;
    tick();
    i_credit_return = 2'b00;
    n_chk++; if ({o_flit_valid, o_flit_type, o_flit_vc, o_flit_data} !== {1'b1, 2'b11, 1'b1, 16'h0004}) $display("FAIL same_cycle_flit: got %h exp %h", {o_flit_valid, o_flit_type, o_flit_vc, o_flit_data}, {1'b1, 2'b11, 1'b1, 16'h0004}); else n_pass++;
    n_chk++; if (dut.r_cred[1] !== 2'd1) $display("FAIL same_cycle_cred1: got %0d exp 1", dut.r_cred[1]); else n_pass++;
    i_credit_return = 2'b01;
    repeat (2) tick();
    n_chk++; if (o_credit_overflow !== 1'b0) $display("FAIL overflow_early: got %b exp 0", o_credit_overflow); else n_pass++;
    tick();
    i_credit_return = 2'b00;
    n_chk++; if (o_credit_overflow !== 1'b1) $display("FAIL overflow_set: got %b exp 1", o_credit_overflow); else n_pass++;
    n_chk++; if (dut.r_cred[0] !== 2'd2) $display("FAIL overflow_saturate: got %0d exp 2", dut.r_cred[0]); else n_pass++;
    repeat (3) tick();
    n_chk++; if (o_credit_overflow !== 1'b1) $display("FAIL overflow_sticky: got %b exp 1", o_credit_overflow); else n_pass++;
    i_credit_return = 2'b10;
    tick();
    i_credit_return = 2'b00;
  endtask

  task automatic test_drop();
    i_msg_valid = 1'b1; i_msg_dest = 3'd0; i_msg_len = 4'd2;
    i_pld_valid = 1'b1; i_pld_data = 16'h1111;
    tick();
    i_msg_valid = 1'b0;
    n_chk++; if (o_pld_ready !== 1'b1) $display("FAIL drop_pld_ready: got %b exp 1", o_pld_ready); else n_pass++;
    tick();
    i_pld_data = 16'h2222;
    n_chk++; if ({o_flit_valid, o_msg_ready} !== 2'b00) $display("FAIL drop_mid: got %b exp 00", {o_flit_valid, o_msg_ready}); else n_pass++;
    tick();
    i_pld_valid = 1'b0;
    n_chk++; if ({o_flit_valid, o_msg_ready, o_pld_ready} !== 3'b010) $display("FAIL drop_done: got %b exp 010", {o_flit_valid, o_msg_ready, o_pld_ready}); else n_pass++;
    n_chk++; if ({dut.r_cred[0], dut.r_cred[1]} !== 4'b1010) $display("FAIL drop_credits: got %h exp a", {dut.r_cred[0], dut.r_cred[1]}); else n_pass++;
  endtask

  task automatic test_reset_clears_overflow();
    rst_n = 1'b0;
    #1;
    n_chk++; if (o_credit_overflow !== 1'b0) $display("FAIL reset_clears_overflow: got %b exp 0", o_credit_overflow); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] msgs [$];
    logic [15:0] words [$];
    logic [17:0] exp_q [$];
    logic [17:0] exp_f;
    logic [15:0] x;
    logic [1:0] ret;
    logic hs_m, hs_p;
    int cred_m [2];
    int d, l, lock_vc, cyc;
    cred_m[0] = 2; cred_m[1] = 2;
    lock_vc = 0; cyc = 0;
    for (int m = 0; m < 40; m++) begin
      d = $urandom_range(0, 7);
      l = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 15);
      msgs.push_back({3'(d), 4'(l)});
      if (d != 0) exp_q.push_back({l == 0 ? 2'b11 : 2'b00, 16'(d + 8 * 0)});
      for (int w = 0; w < l; w++) begin
        x = 16'($urandom);
        words.push_back(x);
        if (d != 0) exp_q.push_back({w == l - 1 ? 2'b10 : 2'b01, x});
      end
    end
    while ((exp_q.size() != 0 || msgs.size() != 0 || words.size() != 0) && cyc < 20000) begin
      cyc++;
      i_msg_valid = msgs.size() != 0 && $urandom_range(0, 3) != 0;
      if (msgs.size() != 0) {i_msg_dest, i_msg_len} = msgs[0];
      i_pld_valid = words.size() != 0 && $urandom_range(0, 3) != 0;
      if (words.size() != 0) i_pld_data = words[0];
      for (int v = 0; v < 2; v++) ret[v] = cred_m[v] < 2 && $urandom_range(0, 2) == 0;
      i_credit_return = ret;
      hs_m = i_msg_valid && o_msg_ready;
      hs_p = i_pld_valid && o_pld_ready;
      tick();
      if (hs_m) void'(msgs.pop_front());
      if (hs_p) void'(words.pop_front());
      if (o_flit_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rand_extra_flit: got %h exp none", {o_flit_type, o_flit_data});
        end else begin
          exp_f = exp_q.pop_front();
          if (exp_f[17:16] == 2'b00 || exp_f[17:16] == 2'b11) lock_vc = cred_m[0] > 0 ? 0 : 1;
          n_chk++; if ({o_flit_type, o_flit_vc, o_flit_data} !== {exp_f[17:16], 1'(lock_vc), exp_f[15:0]}) $display("FAIL rand_flit: got %h exp %h", {o_flit_type, o_flit_vc, o_flit_data}, {exp_f[17:16], 1'(lock_vc), exp_f[15:0]}); else n_pass++;
          n_chk++; if (cred_m[o_flit_vc] <= 0) $display("FAIL rand_credit: got count %0d on vc %0d exp >0", cred_m[o_flit_vc], o_flit_vc); else n_pass++;
          cred_m[o_flit_vc]--;
        end
      end
      for (int v = 0; v < 2; v++) cred_m[v] += int'(ret[v]);
    end
    i_msg_valid = 1'b0; i_pld_valid = 1'b0; i_credit_return = 2'b00;
    n_chk++; if (exp_q.size() + msgs.size() + words.size() != 0) $display("FAIL rand_drain: got %0d items left exp 0", exp_q.size() + msgs.size() + words.size()); else n_pass++;
    n_chk++; if (o_credit_overflow !== 1'b0) $display("FAIL rand_overflow: got %b exp 0", o_credit_overflow); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_head_only();
    test_credit_stall();
    test_vc_select();
    test_same_cycle_overflow();
    test_drop();
    test_reset_clears_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spidergon_flit_injector.md
# spidergon_flit_injector

Network-interface injection stage feeding one spidergon NoC node's local input port. Accepts message descriptors plus payload words from a local source and packetises them into head/body/tail flits. Flits are issued into the node's per-VC input buffers under credit-based flow control, one flit per cycle maximum. One instance per node.

## Interface
- NUM_OF_NODES, 8: nodes in ring; DESTW = clog2(NUM_OF_NODES)
- FLIT_DATA_WIDTH, 16: flit payload bits; must be >= 2*DESTW
- NODE_BUFFER_WIDTH, 32: bits per VC buffer; CREDITS = NODE_BUFFER_WIDTH/FLIT_DATA_WIDTH (2 at defaults)
- NUM_OF_VIRTUAL_CHANNELS, 2: VCs per input port; VCW = max(1, clog2(NUM_OF_VIRTUAL_CHANNELS))
- NODE_ID, 0: this node's address
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- msg_valid  in  1  descriptor valid
- msg_ready  out  1  descriptor accepted when msg_valid & msg_ready
- msg_dest  in  DESTW  destination node
- msg_len  in  4  payload flit count, 0..15 (0 = head-only packet)
- pld_valid  in  1  payload word valid
- pld_ready  out  1  payload word consumed when pld_valid & pld_ready
- pld_data  in  FLIT_DATA_WIDTH  payload word
- flit_valid  out  1  flit present, one cycle per flit
- flit_type  out  2  00 head, 01 body, 10 tail, 11 head+tail
- flit_vc  out  VCW  target VC
- flit_data  out  FLIT_DATA_WIDTH  flit payload
- credit_return  in  NUM_OF_VIRTUAL_CHANNELS  one-cycle pulse per freed buffer slot, per VC
- credit_overflow  out  1  sticky; credit returned to a full counter

## Operation
- FSM states: IDLE, HEAD, BODY, DROP.
- **IDLE:**
  - msg_ready = 1 (0 while reset asserted).
  - On accept, latch dest, len. Clear remaining = len.
  - Go to DROP if dest == NODE_ID, else HEAD.
- **HEAD:**
  - Selected VC = lowest index with credit count != 0. If none, wait.
  - On send, emit head: flit_data[DESTW-1:0] = dest, [2*DESTW-1:DESTW] = NODE_ID, upper bits 0.
  - flit_type = 11 if len == 0 (then IDLE), else 00 (then BODY).
  - The chosen VC is locked for the whole packet.
- **BODY:**
  - pld_ready = credit[locked VC] != 0.
  - Each payload handshake emits one flit with flit_data = pld_data and decrements remaining.
  - Last word (remaining == 1) is type 10, then IDLE. Otherwise type 01.
- **DROP:**
  - pld_ready = 1. Consume len words without emitting flits, then IDLE.
  - len == 0 returns to IDLE directly.
- **Credits:** one counter per VC, 0..CREDITS, reset to CREDITS.
  - Sent flit: -1. Return pulse: +1. Both in the same cycle: unchanged.
  - Return at CREDITS: counter saturates and credit_overflow sets. It clears only on reset.
  - Send decisions use the registered count only. A same-cycle return becomes usable next cycle.
- pld_ready, msg_ready are combinational from state and counters only, never from valid inputs.

## Timing
- **Reset values:** flit_valid = 0, flit_type = 00, flit_vc = 0, flit_data = 0, credit_overflow = 0, state IDLE, counters = CREDITS, msg_ready = 0, pld_ready = 0.
- **Reset mid-packet:** the partial packet is abandoned and no tail is emitted. The NoC is reset together.
- **Output register:** flit outputs are registered. A flit sent at edge E is visible in the cycle after E.
- **Head latency:**
  - Descriptor accepted at edge E0.
  - Head sent at E1 if credit exists; flit_valid is high in the cycle after E1.
  - No credit: the head waits until the first edge with a nonzero count.
- **Throughput:**
  - Body flits go out back-to-back, one per edge, while pld_valid is high and credit is available.
  - A pld_valid gap or zero credit inserts idle cycles (flit_valid = 0).
- **Tail to next message:**
  - After the tail or head+tail edge, msg_ready is high in the next cycle.
  - Minimum packet-to-packet gap is one idle cycle (the descriptor accept cycle).

## Test plan
1. **Reset:** hold reset = 0 for 2 cycles, then release.
   - During reset all outputs are 0.
   - One cycle after release, msg_ready = 1 and both counters = 2.
2. **Head-only packet:** dest = 3, len = 0 → one flit, type 11, vc 0, flit_data = 0x0003 (src 0 in bits [5:3]). VC0 count = 1.
3. **Credit stall:** dest = 5, len = 3, pld = 0xA1, 0xA2, 0xA3 always valid, no returns.
   - Head (vc 0), then body 0xA1, then stall with pld_ready = 0.
   - Pulse credit_return[0] once → 0xA2 body on the next edge.
   - Pulse again → 0xA3 tail.
4. **VC selection:** VC0 count = 0, VC1 = 2, send dest = 2, len = 1 → head and tail on vc 1. VC1 count goes to 0.
5. **Same-cycle and overflow:** credit_return[1] in the same cycle as a VC1 send → count unchanged. credit_return[0] with VC0 count = 2 → credit_overflow = 1, count stays 2, sticky until reset.
6. **Self-addressed drop:** dest = 0 (NODE_ID), len = 2 → two payload words consumed, flit_valid stays 0, counters unchanged. msg_ready is high again 1 cycle after the second word.
